// File: rtl/rat_int_pkg.sv
// Shared sizes and the per-lane rename packet for the integer register alias table.
package rat_int_pkg;

  localparam int RENAME_WIDTH       = 3;
  localparam int ARF_INDEX_SIZE     = 5;
  localparam int PRF_INT_INDEX_SIZE = 6;
  localparam int CP_NUM             = 4;
  localparam int CP_INDEX_SIZE      = 2;
  localparam int ARF_NUM            = 1 << ARF_INDEX_SIZE;

  typedef logic [ARF_INDEX_SIZE-1:0]     arf_idx_t;
  typedef logic [PRF_INT_INDEX_SIZE-1:0] prf_idx_t;

  typedef struct packed {
    logic     valid;
    arf_idx_t rs1;
    arf_idx_t rs2;
    arf_idx_t rd;
    logic     rd_valid;
  } rename_pkt_t;

  // x0 is hardwired to PRF 0, so a write to it never consumes a free register.
  function automatic logic needs_alloc(input rename_pkt_t p);
    return p.valid & p.rd_valid & (p.rd != '0);
  endfunction

endpackage

// File: rtl/rat_bypass.sv
// Intra-group dependency resolution: a lane sees the newest PRF allocated by an older lane
// of the same group for the same arch register, falling back to the map-table value.
module rat_bypass
  import rat_int_pkg::*;
(
  input  logic [RENAME_WIDTH-1:0][ARF_INDEX_SIZE-1:0]     i_src,
  input  logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] i_map_val,
  input  logic [RENAME_WIDTH-1:0]                         i_alloc,
  input  logic [RENAME_WIDTH-1:0][ARF_INDEX_SIZE-1:0]     i_rd,
  input  logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] i_prf_out,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] o_prf
);

  always_comb begin
    o_prf = i_map_val;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      // Ascending scan: the highest older lane that matches is the last to write.
      for (int j = 0; j < k; j++) begin
        if (i_alloc[j] && (i_rd[j] == i_src[k])) begin
          o_prf[k] = i_prf_out[j];
        end
      end
    end
  end

endmodule

// File: rtl/rat_int.sv
// Integer register alias table: renames up to RENAME_WIDTH lanes per cycle and keeps
// CP_NUM map checkpoints in lock-step with the freelist's check/recover protocol.
module rat_int
  import rat_int_pkg::*;
(
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          check,
  input  logic [CP_INDEX_SIZE-1:0]                      check_idx,
  input  logic                                          recover,
  input  logic [CP_INDEX_SIZE-1:0]                      recover_idx,
  input  logic [RENAME_WIDTH-1:0]                       in_valid,
  input  logic [RENAME_WIDTH-1:0][ARF_INDEX_SIZE-1:0]   rs1,
  input  logic [RENAME_WIDTH-1:0][ARF_INDEX_SIZE-1:0]   rs2,
  input  logic [RENAME_WIDTH-1:0][ARF_INDEX_SIZE-1:0]   rd,
  input  logic [RENAME_WIDTH-1:0]                       rd_valid,
  input  logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] prf_out,
  input  logic                                          allocatable,
  output logic [RENAME_WIDTH-1:0]                       prf_req,
  output logic                                          ready,
  output logic [RENAME_WIDTH-1:0]                       out_valid,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] prs1,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] prs2,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] prd,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] prd_old
);

  rename_pkt_t [RENAME_WIDTH-1:0]                   w_pkt;
  logic [RENAME_WIDTH-1:0]                          w_alloc;
  logic                                             w_accept;
  logic [RENAME_WIDTH-1:0][ARF_INDEX_SIZE-1:0]      w_rs1, w_rs2, w_rd;
  logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  w_map_rs1, w_map_rs2, w_map_rd;
  logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  w_prs1, w_prs2, w_old;
  logic [PRF_INT_INDEX_SIZE-1:0]                    w_map_next [ARF_NUM];

  logic [PRF_INT_INDEX_SIZE-1:0]                    r_map [ARF_NUM];
  logic [PRF_INT_INDEX_SIZE-1:0]                    r_cp  [CP_NUM][ARF_NUM];

  logic [RENAME_WIDTH-1:0]                          r_vld_p1;
  logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  r_prs1_p1, r_prs2_p1, r_prd_p1, r_old_p1;

  // Stage 0: decode lanes and read the current map
  always_comb begin
    w_pkt     = '0;
    w_alloc   = '0;
    w_rs1     = '0;
    w_rs2     = '0;
    w_rd      = '0;
    w_map_rs1 = '0;
    w_map_rs2 = '0;
    w_map_rd  = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      w_pkt[k].valid    = in_valid[k];
      w_pkt[k].rs1      = rs1[k];
      w_pkt[k].rs2      = rs2[k];
      w_pkt[k].rd       = rd[k];
      w_pkt[k].rd_valid = rd_valid[k];
      w_alloc[k]   = needs_alloc(w_pkt[k]);
      w_rs1[k]     = w_pkt[k].rs1;
      w_rs2[k]     = w_pkt[k].rs2;
      w_rd[k]      = w_pkt[k].rd;
      w_map_rs1[k] = r_map[w_rs1[k]];
      w_map_rs2[k] = r_map[w_rs2[k]];
      w_map_rd[k]  = r_map[w_rd[k]];
    end
  end

  assign w_accept = !reset && !recover && (allocatable || (w_alloc == '0));
  assign ready    = w_accept;
  assign prf_req  = (reset || recover) ? '0 : w_alloc;

  rat_bypass u_byp_rs1 (
    .i_src     (w_rs1),
    .i_map_val (w_map_rs1),
    .i_alloc   (w_alloc),
    .i_rd      (w_rd),
    .i_prf_out (prf_out),
    .o_prf     (w_prs1)
  );

  rat_bypass u_byp_rs2 (
    .i_src     (w_rs2),
    .i_map_val (w_map_rs2),
    .i_alloc   (w_alloc),
    .i_rd      (w_rd),
    .i_prf_out (prf_out),
    .o_prf     (w_prs2)
  );

  rat_bypass u_byp_rd (
    .i_src     (w_rd),
    .i_map_val (w_map_rd),
    .i_alloc   (w_alloc),
    .i_rd      (w_rd),
    .i_prf_out (prf_out),
    .o_prf     (w_old)
  );

  // Map after this cycle's renames; ascending lane order lets the youngest WAW writer win.
  always_comb begin
    for (int i = 0; i < ARF_NUM; i++) begin
      w_map_next[i] = r_map[i];
    end
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      if (w_accept && w_alloc[k]) begin
        w_map_next[w_rd[k]] = prf_out[k];
      end
    end
  end

  // Stage 1: map/checkpoint state and registered rename results
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ARF_NUM; i++) begin
        r_map[i] <= PRF_INT_INDEX_SIZE'(i);
        for (int c = 0; c < CP_NUM; c++) begin
          r_cp[c][i] <= PRF_INT_INDEX_SIZE'(i);
        end
      end
      r_vld_p1  <= '0;
      r_prs1_p1 <= '0;
      r_prs2_p1 <= '0;
      r_prd_p1  <= '0;
      r_old_p1  <= '0;
    end else begin
      if (recover) begin
        for (int i = 0; i < ARF_NUM; i++) begin
          r_map[i] <= r_cp[recover_idx][i];
        end
      end else begin
        for (int i = 0; i < ARF_NUM; i++) begin
          r_map[i] <= w_map_next[i];
          if (check) begin
            r_cp[check_idx][i] <= w_map_next[i];
          end
        end
      end
      for (int k = 0; k < RENAME_WIDTH; k++) begin
        r_vld_p1[k] <= w_accept && in_valid[k];
        if (w_accept && in_valid[k]) begin
          r_prs1_p1[k] <= w_prs1[k];
          r_prs2_p1[k] <= w_prs2[k];
          r_prd_p1[k]  <= w_alloc[k] ? prf_out[k] : '0;
          r_old_p1[k]  <= (w_rd[k] == '0) ? '0 : w_old[k];
        end else begin
          r_prs1_p1[k] <= '0;
          r_prs2_p1[k] <= '0;
          r_prd_p1[k]  <= '0;
          r_old_p1[k]  <= '0;
        end
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign prs1      = r_prs1_p1;
  assign prs2      = r_prs2_p1;
  assign prd       = r_prd_p1;
  assign prd_old   = r_old_p1;

endmodule
